// File: rtl/gen_fifo_defines_pkg.sv
// Shared generator defaults and the commit FSM state type for the shadow register bank.
package gen_fifo_defines_pkg;

    localparam int GEN_DATA_WIDTH = 8;
    localparam logic [GEN_DATA_WIDTH-1:0] GEN_RESET_VALUE = '0;
    localparam int GEN_NUM_CH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } regbank_state_e;

endpackage

// File: rtl/funct_generator_regbank_ch.sv
// One channel of the shadow bank: a stage word, the active word the datapath sees, and a pending flag.
module funct_generator_regbank_ch
    import gen_fifo_defines_pkg::*;
#(
    parameter int                    DATA_WIDTH  = GEN_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  ld_stage,
    input  logic                  ld_active,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] active,
    output logic                  pending
);

    logic [DATA_WIDTH-1:0] stage_q, stage_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic                  pending_q, pending_d;

    always_comb begin
        stage_d   = stage_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (clr) begin
            stage_d   = RESET_VALUE;
            active_d  = RESET_VALUE;
            pending_d = 1'b0;
        end else begin
            // Only channels that were actually staged move to the active word.
            if (ld_active && pending_q) begin
                active_d  = stage_q;
                pending_d = 1'b0;
            end
            if (ld_stage) begin
                stage_d   = wr_data;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= RESET_VALUE;
            active_q  <= RESET_VALUE;
            pending_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign active  = active_q;
    assign pending = pending_q;

endmodule

// File: rtl/funct_generator_shadow_regbank.sv
// Multi-channel double-buffered generator control bank; a commit FSM moves all staged words to q at once.
module funct_generator_shadow_regbank
    import gen_fifo_defines_pkg::*;
#(
    parameter int                    DATA_WIDTH  = GEN_DATA_WIDTH,
    parameter int                    NUM_CH      = GEN_NUM_CH,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = DATA_WIDTH'(GEN_RESET_VALUE),
    localparam int                   CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clrh,
    input  logic                         wr_en,
    input  logic [CH_W-1:0]              wr_ch,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_ready,
    input  logic                         commit_req,
    input  logic                         sync_mode,
    input  logic                         boundary,
    output logic [NUM_CH*DATA_WIDTH-1:0] q,
    output logic [NUM_CH-1:0]            pending,
    output logic                         busy,
    output logic                         commit_done,
    output logic                         wr_err
);

    regbank_state_e state_q, state_d;
    logic req_q, req_d;
    logic mode_q, mode_d;
    logic bnd_q, bnd_d;
    logic commit_done_q, commit_done_d;
    logic wr_err_q, wr_err_d;

    logic              wr_ok;
    logic              ch_in_range;
    logic              ld_active;
    logic [NUM_CH-1:0] ld_stage;

    assign wr_ready    = (state_q != COMMIT);
    assign busy        = (state_q != IDLE);
    assign ch_in_range = (32'(wr_ch) < NUM_CH);
    assign wr_ok       = wr_en & wr_ready & ~clrh;
    assign ld_active   = (state_q == COMMIT) & ~clrh;

    // Requests and boundaries are captured one cycle before the FSM acts on them,
    // and only in the state where they mean something.
    always_comb begin
        state_d       = state_q;
        req_d         = commit_req & (state_q == IDLE);
        mode_d        = sync_mode;
        bnd_d         = boundary & (state_q == ARMED);
        commit_done_d = 1'b0;
        wr_err_d      = wr_ok & ~ch_in_range;
        case (state_q)
            IDLE:    if (req_q) state_d = mode_q ? ARMED : COMMIT;
            ARMED:   if (bnd_q) state_d = COMMIT;
            COMMIT: begin
                state_d       = IDLE;
                commit_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (clrh) begin
            state_d       = IDLE;
            req_d         = 1'b0;
            bnd_d         = 1'b0;
            commit_done_d = 1'b0;
            wr_err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            mode_q        <= 1'b0;
            bnd_q         <= 1'b0;
            commit_done_q <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            mode_q        <= mode_d;
            bnd_q         <= bnd_d;
            commit_done_q <= commit_done_d;
            wr_err_q      <= wr_err_d;
        end
    end

    assign commit_done = commit_done_q;
    assign wr_err      = wr_err_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ld_stage[gi] = wr_ok & (wr_ch == CH_W'(gi));

            funct_generator_regbank_ch #(
                .DATA_WIDTH  (DATA_WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (clrh),
                .ld_stage  (ld_stage[gi]),
                .ld_active (ld_active),
                .wr_data   (wr_data),
                .active    (q[gi*DATA_WIDTH +: DATA_WIDTH]),
                .pending   (pending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_funct_generator_shadow_regbank.sv
// Randomized check of the shadow register bank against a transaction-level stage/active model.
module tb_funct_generator_shadow_regbank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clrh = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        commit_req = 1'b0;
    logic        sync_mode = 1'b0;
    logic        boundary = 1'b0;
    logic [31:0] q;
    logic [3:0]  pending;
    logic        busy;
    logic        commit_done;
    logic        wr_err;

    // Three-channel build for out-of-range index checks.
    logic        w3_en = 1'b0;
    logic [1:0]  w3_ch = '0;
    logic [7:0]  w3_data = '0;
    logic        w3_ready;
    logic [23:0] q3;
    logic [2:0]  pending3;
    logic        busy3;
    logic        done3;
    logic        err3;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_stage [4];
    logic [7:0] m_act   [4];
    logic [3:0] m_pend;

    always #5 clk = ~clk;

    funct_generator_shadow_regbank #(.DATA_WIDTH(8), .NUM_CH(4), .RESET_VALUE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .clrh(clrh),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data), .wr_ready(wr_ready),
        .commit_req(commit_req), .sync_mode(sync_mode), .boundary(boundary),
        .q(q), .pending(pending), .busy(busy), .commit_done(commit_done), .wr_err(wr_err)
    );

    funct_generator_shadow_regbank #(.DATA_WIDTH(8), .NUM_CH(3), .RESET_VALUE(8'h00)) dut3 (
        .clk(clk), .rst_n(rst_n), .clrh(clrh),
        .wr_en(w3_en), .wr_ch(w3_ch), .wr_data(w3_data), .wr_ready(w3_ready),
        .commit_req(1'b0), .sync_mode(1'b0), .boundary(1'b0),
        .q(q3), .pending(pending3), .busy(busy3), .commit_done(done3), .wr_err(err3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_q();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_act[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_stage[i] = 8'h00;
            m_act[i]   = 8'h00;
        end
        m_pend = 4'b0000;
    endtask

    task automatic model_commit();
        for (int i = 0; i < 4; i++)
            if (m_pend[i]) m_act[i] = m_stage[i];
        m_pend = 4'b0000;
    endtask

    task automatic do_write(input int ch, input logic [7:0] data);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_data = data;
        tick();
        wr_en = 1'b0;
        m_stage[ch] = data;
        m_pend[ch]  = 1'b1;
        $display("write ch%0d=%02h pending=%b", ch, data, pending);
        chk("wr_pending", pending, m_pend);
        chk("wr_q_hold", q, exp_q());
        chk("wr_err_low", wr_err, 1'b0);
    endtask

    task automatic commit_imm(input bit with_wr);
        logic [31:0] old_q;
        old_q = exp_q();
        commit_req = 1'b1; sync_mode = 1'b0;
        if (with_wr) begin
            wr_en = 1'b1; wr_ch = 2'($urandom_range(0, 3)); wr_data = 8'($urandom);
            m_stage[wr_ch] = wr_data;
            m_pend[wr_ch]  = 1'b1;
        end
        tick();
        commit_req = 1'b0; wr_en = 1'b0;
        chk("imm_n_busy", busy, 1'b0);
        chk("imm_n_pending", pending, m_pend);
        tick();
        chk("imm_commit_busy", busy, 1'b1);
        chk("imm_commit_ready", wr_ready, 1'b0);
        chk("imm_commit_done_early", commit_done, 1'b0);
        chk("imm_commit_q_old", q, old_q);
        // This write lands in the COMMIT cycle and must vanish.
        wr_en = 1'b1; wr_ch = 2'($urandom_range(0, 3)); wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        model_commit();
        $display("commit imm q=%08h done=%0b pending=%b", q, commit_done, pending);
        chk("imm_q", q, exp_q());
        chk("imm_done", commit_done, 1'b1);
        chk("imm_pending_clr", pending, m_pend);
        chk("imm_idle", busy, 1'b0);
        tick();
        chk("imm_done_pulse", commit_done, 1'b0);
        chk("imm_dropped_write", pending, 4'b0000);
    endtask

    task automatic commit_sync(input int nwait, input bit rnd_wr);
        logic [31:0] old_q;
        old_q = exp_q();
        commit_req = 1'b1; sync_mode = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        chk("sync_armed_busy", busy, 1'b1);
        for (int k = 0; k < nwait; k++) begin
            if (rnd_wr && $urandom_range(0, 2) == 0)
                do_write($urandom_range(0, 3), 8'($urandom));
            else
                tick();
            chk("sync_wait_q", q, old_q);
            chk("sync_wait_done", commit_done, 1'b0);
        end
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        tick();
        chk("sync_m1_q_old", q, old_q);
        chk("sync_m1_done", commit_done, 1'b0);
        tick();
        model_commit();
        $display("commit sync wait=%0d q=%08h done=%0b", nwait, q, commit_done);
        chk("sync_q", q, exp_q());
        chk("sync_done", commit_done, 1'b1);
        chk("sync_pending_clr", pending, m_pend);
        tick();
        chk("sync_done_pulse", commit_done, 1'b0);
    endtask

    initial begin
        int dones;
        model_clear();
        #1;
        chk("rst_q", q, 32'h0);
        chk("rst_busy", busy, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (5) tick();
        $display("reset released q=%08h pending=%b busy=%0b", q, pending, busy);
        chk("idle_q", q, 32'h0);
        chk("idle_pending", pending, 4'b0000);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", wr_ready, 1'b1);

        // Out-of-range channel on the three-channel build.
        w3_en = 1'b1; w3_ch = 2'd3; w3_data = 8'h77;
        tick();
        w3_en = 1'b0;
        $display("nch3 write ch3 err=%0b pending=%b", err3, pending3);
        chk("n3_err_pulse", err3, 1'b1);
        chk("n3_err_pending", pending3, 3'b000);
        tick();
        chk("n3_err_clear", err3, 1'b0);
        w3_en = 1'b1; w3_ch = 2'd2; w3_data = 8'h12;
        tick();
        w3_en = 1'b0;
        $display("nch3 write ch2 err=%0b pending=%b", err3, pending3);
        chk("n3_ok_err", err3, 1'b0);
        chk("n3_ok_pending", pending3, 3'b100);

        // Directed immediate commit of two channels.
        do_write(1, 8'h5A);
        do_write(3, 8'hC3);
        chk("dir_pending_1010", pending, 4'b1010);
        commit_imm(1'b0);
        chk("dir_q_1_3", q, 32'hC3005A00);

        // Directed sync commit with a long armed wait and a write while armed.
        do_write(0, 8'h11);
        commit_req = 1'b1; sync_mode = 1'b1;
        tick();
        commit_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("dir_armed_q0", q[7:0], 8'h00);
        end
        do_write(2, 8'h22);
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        tick();
        chk("dir_sync_m1", q, 32'hC3005A00);
        tick();
        model_commit();
        $display("dir sync q=%08h done=%0b", q, commit_done);
        chk("dir_sync_q", q, 32'hC3225A11);
        chk("dir_sync_done", commit_done, 1'b1);

        // Empty commit still pulses once and leaves q alone.
        tick();
        commit_imm(1'b0);

        // clrh while armed.
        do_write(1, 8'hAB);
        do_write(2, 8'hCD);
        chk("clr_pending_0110", pending, 4'b0110);
        commit_req = 1'b1; sync_mode = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        clrh = 1'b1;
        tick();
        clrh = 1'b0;
        model_clear();
        $display("clrh armed q=%08h pending=%b busy=%0b", q, pending, busy);
        chk("clr_busy", busy, 1'b0);
        chk("clr_pending", pending, 4'b0000);
        chk("clr_q", q, 32'h0);
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("clr_no_done", commit_done, 1'b0);
            tick();
        end

        // commit_req held four cycles: exactly two commits.
        do_write(0, 8'h3C);
        commit_req = 1'b1; sync_mode = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (commit_done) dones++;
        end
        commit_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (commit_done) dones++;
        end
        model_commit();
        $display("held req commits=%0d q=%08h", dones, q);
        chk("held_commits", dones, 2);
        chk("held_q", q, exp_q());

        // Randomized transactions.
        for (int it = 0; it < 40; it++) begin
            int nwr;
            nwr = $urandom_range(0, 3);
            for (int w = 0; w < nwr; w++) do_write($urandom_range(0, 3), 8'($urandom));
            if ($urandom_range(0, 1) == 0) commit_imm(1'($urandom_range(0, 1)));
            else commit_sync($urandom_range(0, 6), 1'b1);
        end

        // Asynchronous reset in the middle of ARMED.
        do_write(3, 8'h99);
        commit_req = 1'b1; sync_mode = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        $display("async reset mid-armed q=%08h pending=%b busy=%0b", q, pending, busy);
        chk("arst_q", q, 32'h0);
        chk("arst_pending", pending, 4'b0000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", commit_done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        tick(); tick();
        chk("arst_no_commit_q", q, 32'h0);
        chk("arst_no_done", commit_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
